// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the shared RTC bus between the read and write engines, schedules periodic
// read sweeps and inserts an idle guard after every grant. Watchdog: RTC_SCHED_TIMEOUT_EN.
module rtc_bus_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 100_000_000,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       wr_req,
  input  logic       wr_done,
  input  logic       wr_AD,
  input  logic       wr_CS,
  input  logic       wr_RD,
  input  logic       wr_WR,
  input  logic [7:0] wr_data,
  input  logic       rd_done,
  input  logic       rd_AD,
  input  logic       rd_CS,
  input  logic       rd_RD,
  input  logic       rd_WR,
  input  logic [7:0] rd_data,
  output logic       rd_start,
  output logic       rd_grant,
  output logic       wr_grant,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] Data_RTC_out,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT_WR, GRANT_RD, GUARD} state_t;

  state_t        state, state_next;
  logic [RW-1:0] ref_cnt;
  logic [GW-1:0] guard_cnt;
  logic          rd_pending;
  logic          last_wr;
  logic          ref_tick;
  logic          rd_req;
  logic          enter_rd;
  logic          enter_wr;
  logic          guard_done;
  logic          to_hit;

  // The wrap tick counts as a read request in the same cycle, so an idle bus
  // launches the sweep on the cycle right after the last refresh count.
  assign ref_tick   = EN && (ref_cnt == REF_LAST);
  assign rd_req     = rd_pending || ref_tick;
  assign enter_rd   = (state == IDLE) && (state_next == GRANT_RD);
  assign enter_wr   = (state == IDLE) && (state_next == GRANT_WR);
  assign guard_done = (guard_cnt == GUARD_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ref_cnt <= '0;
    end else if (EN) begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + RW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_pending <= 1'b0;
      last_wr    <= 1'b0;
      rd_start   <= 1'b0;
    end else begin
      if (enter_rd) begin
        rd_pending <= 1'b0;
      end else if (ref_tick) begin
        rd_pending <= 1'b1;
      end
      if (enter_wr) begin
        last_wr <= 1'b1;
      end else if (enter_rd) begin
        last_wr <= 1'b0;
      end
      rd_start <= enter_rd;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      guard_cnt <= '0;
    end else if (state == GUARD) begin
      guard_cnt <= guard_cnt + GW'(1);
    end else begin
      guard_cnt <= '0;
    end
  end

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  assign to_hit = (to_cnt == TO_LAST) &&
                  (((state == GRANT_WR) && !wr_done) || ((state == GRANT_RD) && !rd_done));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == GRANT_WR) || (state == GRANT_RD)) begin
        to_cnt <= to_cnt + TW'(1);
      end else begin
        to_cnt <= '0;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Simultaneous requests alternate on last_wr so writes cannot starve refresh.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (EN) begin
          if (wr_req && rd_req) begin
            state_next = last_wr ? GRANT_RD : GRANT_WR;
          end else if (wr_req) begin
            state_next = GRANT_WR;
          end else if (rd_req) begin
            state_next = GRANT_RD;
          end
        end
      end
      GRANT_WR: if (wr_done || to_hit) state_next = GUARD;
      GRANT_RD: if (rd_done || to_hit) state_next = GUARD;
      GUARD:    if (guard_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_grant     = 1'b0;
    rd_grant     = 1'b0;
    AD           = 1'b1;
    CS           = 1'b1;
    RD           = 1'b1;
    WR           = 1'b1;
    Data_RTC_out = 8'h00;
    busy         = (state != IDLE);
    case (state)
      GRANT_WR: begin
        wr_grant     = 1'b1;
        AD           = wr_AD;
        CS           = wr_CS;
        RD           = wr_RD;
        WR           = wr_WR;
        Data_RTC_out = wr_data;
      end
      GRANT_RD: begin
        rd_grant     = 1'b1;
        AD           = rd_AD;
        CS           = rd_CS;
        RD           = rd_RD;
        WR           = rd_WR;
        Data_RTC_out = rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: table-driven bus-mux vectors plus hand-written
// arbitration, guard, enable, watchdog and reset sequences.
module tb_rtc_bus_scheduler;
  localparam int unsigned REF = 20;
  localparam int unsigned GC  = 4;
  localparam int unsigned TO  = 16;

  logic       CLK = 1'b0;
  logic       RST, EN;
  logic       wr_req, wr_done, wr_AD, wr_CS, wr_RD, wr_WR;
  logic [7:0] wr_data;
  logic       rd_done, rd_AD, rd_CS, rd_RD, rd_WR;
  logic [7:0] rd_data;
  logic       rd_start, rd_grant, wr_grant, AD, CS, RD, WR, busy, timeout_err;
  logic [7:0] Data_RTC_out;

  int nvec  = 0;
  int nfail = 0;

  rtc_bus_scheduler #(
    .REFRESH_CYCLES(REF),
    .GUARD_CYCLES  (GC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .wr_req(wr_req), .wr_done(wr_done),
    .wr_AD(wr_AD), .wr_CS(wr_CS), .wr_RD(wr_RD), .wr_WR(wr_WR), .wr_data(wr_data),
    .rd_done(rd_done),
    .rd_AD(rd_AD), .rd_CS(rd_CS), .rd_RD(rd_RD), .rd_WR(rd_WR), .rd_data(rd_data),
    .rd_start(rd_start), .rd_grant(rd_grant), .wr_grant(wr_grant),
    .AD(AD), .CS(CS), .RD(RD), .WR(WR), .Data_RTC_out(Data_RTC_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // phase: 0 = idle/guard, 1 = write granted, 2 = read granted; strobes packed {AD,CS,RD,WR}
  typedef struct {
    logic [1:0] phase;
    logic [3:0] wr_s;
    logic [7:0] wr_d;
    logic [3:0] rd_s;
    logic [7:0] rd_d;
    logic [3:0] exp_s;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [3:0] exp_s, input logic [7:0] exp_d);
    check({name, "_strb"}, {28'd0, AD, CS, RD, WR}, {28'd0, exp_s});
    check({name, "_data"}, {24'd0, Data_RTC_out}, {24'd0, exp_d});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic idle_inputs();
    {wr_AD, wr_CS, wr_RD, wr_WR} = 4'hF;
    {rd_AD, rd_CS, rd_RD, rd_WR} = 4'hF;
    wr_data = 8'h00;
    rd_data = 8'h00;
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic do_reset();
    RST    = 1'b0;
    EN     = 1'b1;
    wr_req = 1'b0;
    idle_inputs();
    steps(2);
    RST = 1'b1;
  endtask

  task automatic apply_table(input logic [1:0] phase);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].phase == phase) begin
        {wr_AD, wr_CS, wr_RD, wr_WR} = vecs[i].wr_s;
        wr_data                      = vecs[i].wr_d;
        {rd_AD, rd_CS, rd_RD, rd_WR} = vecs[i].rd_s;
        rd_data                      = vecs[i].rd_d;
        #1;
        check_bus($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_d);
      end
    end
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{2'd1, 4'b1010, 8'hA5, 4'b0101, 8'h3C, 4'b1010, 8'hA5};
    vecs[1] = '{2'd1, 4'b0000, 8'hFF, 4'b1111, 8'h00, 4'b0000, 8'hFF};
    vecs[2] = '{2'd1, 4'b1101, 8'h5A, 4'b0010, 8'hC3, 4'b1101, 8'h5A};
    vecs[3] = '{2'd2, 4'b1010, 8'hA5, 4'b0101, 8'h3C, 4'b0101, 8'h3C};
    vecs[4] = '{2'd2, 4'b0000, 8'h00, 4'b1011, 8'h81, 4'b1011, 8'h81};
    vecs[5] = '{2'd2, 4'b1111, 8'hFF, 4'b0000, 8'h7E, 4'b0000, 8'h7E};
    vecs[6] = '{2'd0, 4'b0000, 8'hA5, 4'b0000, 8'h3C, 4'b1111, 8'h00};
    vecs[7] = '{2'd0, 4'b0101, 8'hFF, 4'b1010, 8'hFF, 4'b1111, 8'h00};

    // Reset values and first automatic read sweep
    RST = 1'b0; EN = 1'b1; wr_req = 1'b0; idle_inputs();
    #3;
    check("rst_rd_start", rd_start, 0);
    check("rst_rd_grant", rd_grant, 0);
    check("rst_wr_grant", wr_grant, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check_bus("rst_bus", 4'hF, 8'h00);
    apply_table(2'd0);
    steps(2);
    RST = 1'b1;
    steps(19);
    check("refresh_pre_busy", busy, 0);
    check("refresh_pre_rd_start", rd_start, 0);
    step();
    check("refresh_rd_start", rd_start, 1);
    check("refresh_rd_grant", rd_grant, 1);
    check("refresh_wr_grant", wr_grant, 0);
    check("refresh_busy", busy, 1);
    apply_table(2'd2);
    step();
    check("rd_start_pulse_end", rd_start, 0);
    check("rd_grant_held", rd_grant, 1);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    check("rd_ignores_wr_done", rd_grant, 1);
    {rd_AD, rd_CS, rd_RD, rd_WR} = 4'h0; rd_data = 8'h3C;
    rd_done = 1'b1; step(); rd_done = 1'b0;
    check("rd_guard_grant", rd_grant, 0);
    check("rd_guard_busy", busy, 1);
    check_bus("rd_guard_bus", 4'hF, 8'h00);
    apply_table(2'd0);
    steps(3);
    check("rd_guard_last_busy", busy, 1);
    step();
    check("rd_guard_to_idle", busy, 0);

    // Write grant, ignored read done, wr_req dropped before done
    do_reset();
    wr_req = 1'b1; wr_data = 8'hA5; wr_CS = 1'b0;
    #1;
    check("wr_idle_grant", wr_grant, 0);
    check_bus("wr_idle_bus", 4'hF, 8'h00);
    step();
    check("wr_grant", wr_grant, 1);
    check("wr_no_rd_start", rd_start, 0);
    check_bus("wr_bus", 4'b1011, 8'hA5);
    apply_table(2'd1);
    wr_data = 8'hA5; wr_CS = 1'b0;
    rd_done = 1'b1; step(); rd_done = 1'b0;
    check("wr_ignores_rd_done", wr_grant, 1);
    wr_req = 1'b0; step();
    check("wr_held_after_req_drop", wr_grant, 1);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    check("wr_guard_grant", wr_grant, 0);
    check("wr_guard_busy", busy, 1);
    check_bus("wr_guard_bus", 4'hF, 8'h00);
    steps(3);
    check("wr_guard_last_busy", busy, 1);
    step();
    check("wr_guard_to_idle", busy, 0);

    // Write and pending read collide with last_wr=0
    do_reset();
    steps(19);
    wr_req = 1'b1;
    step();
    check("arb_first_wr", wr_grant, 1);
    check("arb_first_no_rd_start", rd_start, 0);
    wr_done = 1'b1; step(); wr_done = 1'b0;
    check("arb_guard1_wr_grant", wr_grant, 0);
    steps(3);
    check("arb_guard1_waits", wr_grant, 0);
    check("arb_guard1_busy", busy, 1);
    step();
    check("arb_idle1", busy, 0);
    step();
    check("arb_then_rd", rd_grant, 1);
    check("arb_then_rd_start", rd_start, 1);
    check("arb_then_rd_no_wr", wr_grant, 0);
    steps(2);
    check("arb_wr_waits_rd", wr_grant, 0);
    check("arb_rd_held", rd_grant, 1);
    rd_done = 1'b1; step(); rd_done = 1'b0;
    check("arb_guard2_rd_grant", rd_grant, 0);
    steps(3);
    check("arb_guard2_waits", wr_grant, 0);
    step();
    check("arb_idle2", busy, 0);
    step();
    check("arb_wr_after_rd", wr_grant, 1);

    // EN low during a read grant: grant completes, nothing new, counter frozen
    do_reset();
    steps(20);
    check("en_rd_grant", rd_grant, 1);
    EN = 1'b0;
    steps(5);
    check("en_low_grant_held", rd_grant, 1);
    rd_done = 1'b1; step(); rd_done = 1'b0;
    check("en_low_guard", busy, 1);
    steps(4);
    check("en_low_idle", busy, 0);
    wr_req = 1'b1;
    steps(3);
    check("en_low_no_wr_grant", wr_grant, 0);
    check("en_low_stays_idle", busy, 0);
    wr_req = 1'b0; EN = 1'b1;
    steps(19);
    check("en_counter_held_pre", rd_grant, 0);
    step();
    check("en_counter_held_start", rd_start, 1);
    check("en_counter_held_grant", rd_grant, 1);

    // Grant held with no done
    do_reset();
    wr_req = 1'b1;
    step();
    check("to_wr_grant", wr_grant, 1);
    steps(TO - 1);
    check("to_before_limit_grant", wr_grant, 1);
    check("to_before_limit_err", timeout_err, 0);
`ifdef RTC_SCHED_TIMEOUT_EN
    step();
    check("to_forced_guard_grant", wr_grant, 0);
    check("to_forced_guard_busy", busy, 1);
    check("to_err_set", timeout_err, 1);
    steps(10);
    check("to_err_sticky", timeout_err, 1);
    RST = 1'b0;
    #1;
    check("to_err_cleared_by_rst", timeout_err, 0);
`else
    steps(20);
    check("no_to_grant_held", wr_grant, 1);
    check("no_to_err_zero", timeout_err, 0);
`endif

    // Asynchronous reset in the middle of a write grant
    do_reset();
    wr_req = 1'b1; wr_CS = 1'b0; wr_data = 8'hA5;
    step();
    check("arst_pre_grant", wr_grant, 1);
    check_bus("arst_pre_bus", 4'b1011, 8'hA5);
    #2;
    RST = 1'b0;
    #1;
    check("arst_wr_grant", wr_grant, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_start", rd_start, 0);
    check_bus("arst_bus", 4'hF, 8'h00);
    wr_req = 1'b0;
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
